// File: rtl/cmp_pkg.sv
// Shared definitions for compare_arb: op encodings, FSM state encoding,
// default datapath width and the latency-counter helper.
package cmp_pkg;

    // Default datapath width
    localparam int unsigned CMP_N_DEFAULT = 16;

    // Compare op encodings carried on rX_op / dp_op
    typedef enum logic [1:0] {
        OP_SEQ = 2'b00,
        OP_SLT = 2'b01,
        OP_SLE = 2'b10,
        OP_SCO = 2'b11
    } cmp_op_e;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    // DP_LAT is 1..4, so the reload value DP_LAT-1 fits in two bits
    localparam int unsigned CNT_W = 2;

    // Value loaded into the latency counter on accept
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter for compare_arb. Holds the last-grant pointer.
// Macro COMPARE_ARB_FIXED_PRIO_EN selects fixed priority (r0 wins) instead of
// round robin; the pointer is then not built.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef COMPARE_ARB_FIXED_PRIO_EN

    logic w_unused;
    assign w_unused = ^{clk, rst_n, accept};

    // Fixed priority: r0 always beats r1
    always_comb begin
        grant = 2'b00;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

`else

    // 0: r0 was granted last, 1: r1 was granted last
    logic r_last;

    // Round robin: on contention grant the requester not granted last
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = r_last ? 2'b01 : 2'b10;
        end
    end

    // Pointer moves only when a grant is actually taken; reset makes r0 win first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (accept) begin
            r_last <= grant[1];
        end
    end

`endif

endmodule

// File: rtl/compare_arb.sv
// compare_arb: arbitrates two requesters onto one shared compare datapath.
// IDLE accepts one op, BUSY drives the datapath for DP_LAT cycles, RESP holds
// the result until handshaken. Optional macro: COMPARE_ARB_FIXED_PRIO_EN
// (fixed priority, r0 wins) -- default build is round robin.
module compare_arb
    import cmp_pkg::*;
#(
    parameter int unsigned N      = CMP_N_DEFAULT,
    parameter int unsigned DP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [N-1:0] r0_a,
    input  logic [N-1:0] r0_b,
    input  logic [1:0]   r0_op,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [N-1:0] r1_a,
    input  logic [N-1:0] r1_b,
    input  logic [1:0]   r1_op,
    output logic [N-1:0] dp_a,
    output logic [N-1:0] dp_b,
    output logic [1:0]   dp_op,
    input  logic [N-1:0] dp_out,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [N-1:0] resp_data,
    input  logic         resp_ready
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(DP_LAT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [1:0]       r_op;
    logic             r_id;
    logic [N-1:0]     r_resp_data;

    logic             w_idle;
    logic             w_busy;
    logic             w_resp;
    logic [1:0]       w_arb_valid;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_cnt_zero;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_busy     = (r_state == ST_BUSY);
    assign w_resp     = (r_state == ST_RESP);
    assign w_cnt_zero = (r_cnt == '0);

    // Requests are only visible to the arbiter in IDLE and out of reset, so
    // ready can never rise in BUSY/RESP or while rst_n is low
    assign w_arb_valid = {r1_valid, r0_valid} & {2{w_idle & rst_n}};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (w_arb_valid),
        .accept (w_accept),
        .grant  (w_grant)
    );

    // Grant already implies valid, so any grant is an accept
    assign r0_ready = w_grant[0];
    assign r1_ready = w_grant[1];
    assign w_accept = |w_grant;

    // Next-state and latency-counter logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = ST_BUSY;
                    w_cnt_d   = LAT_LOAD;
                end
            end
            ST_BUSY: begin
                if (w_cnt_zero) begin
                    w_state_d = ST_RESP;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Op register: capture the winner's operands, op and id on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= 2'b00;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_a  <= w_grant[1] ? r1_a  : r0_a;
            r_b  <= w_grant[1] ? r1_b  : r0_b;
            r_op <= w_grant[1] ? r1_op : r0_op;
            r_id <= w_grant[1];
        end
    end

    // Result register: sample dp_out in the last BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_data <= '0;
        end else if (w_busy && w_cnt_zero) begin
            r_resp_data <= dp_out;
        end
    end

    // Datapath is driven only while BUSY, zero otherwise
    assign dp_a  = w_busy ? r_a  : '0;
    assign dp_b  = w_busy ? r_b  : '0;
    assign dp_op = w_busy ? r_op : 2'b00;

    // Response outputs are quiet outside RESP
    assign resp_valid = w_resp;
    assign resp_id    = w_resp ? r_id        : 1'b0;
    assign resp_data  = w_resp ? r_resp_data : '0;

endmodule

// File: tb/tb_compare_arb.sv
// Self-checking bench for compare_arb: a DP_LAT=1 instance under directed and
// random stimulus against a transaction-timing model, plus a DP_LAT=3 instance
// under directed stimulus.
module tb_compare_arb;
    import cmp_pkg::*;

    localparam int N    = 16;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT (DP_LAT=1)
    logic         r0_valid = 0, r1_valid = 0, r0_ready, r1_ready;
    logic [N-1:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
    logic [1:0]   r0_op = 0, r1_op = 0;
    logic [N-1:0] dp_a, dp_b, dp_out, resp_data;
    logic [1:0]   dp_op;
    logic         resp_valid, resp_id;
    logic         resp_ready = 0;

    // Second DUT (DP_LAT=3)
    logic         t_r0_valid = 0, t_r1_valid = 0, t_r0_ready, t_r1_ready;
    logic [N-1:0] t_r0_a = 0, t_r0_b = 0, t_r1_a = 0, t_r1_b = 0;
    logic [1:0]   t_r0_op = 0, t_r1_op = 0;
    logic [N-1:0] t_dp_a, t_dp_b, t_resp_data;
    logic [N-1:0] t_dp_out = 0;
    logic [1:0]   t_dp_op;
    logic         t_resp_valid, t_resp_id;
    logic         t_resp_ready = 0;

    compare_arb #(.N(N), .DP_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op), .dp_out(dp_out),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_ready(resp_ready)
    );

    compare_arb #(.N(N), .DP_LAT(LAT3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(t_r0_valid), .r0_ready(t_r0_ready), .r0_a(t_r0_a), .r0_b(t_r0_b),
        .r0_op(t_r0_op),
        .r1_valid(t_r1_valid), .r1_ready(t_r1_ready), .r1_a(t_r1_a), .r1_b(t_r1_b),
        .r1_op(t_r1_op),
        .dp_a(t_dp_a), .dp_b(t_dp_b), .dp_op(t_dp_op), .dp_out(t_dp_out),
        .resp_valid(t_resp_valid), .resp_id(t_resp_id), .resp_data(t_resp_data),
        .resp_ready(t_resp_ready)
    );

    // External compare datapath: SEQ/SLT/SLE signed, SCO as unsigned borrow
    function automatic logic [N-1:0] cmp_model(input logic [1:0] op,
                                               input logic [N-1:0] a, input logic [N-1:0] b);
        logic res;
        case (op)
            2'b00:   res = (a == b);
            2'b01:   res = ($signed(a) <  $signed(b));
            2'b10:   res = ($signed(a) <= $signed(b));
            default: res = (a < b);
        endcase
        return {{(N-1){1'b0}}, res};
    endfunction

    assign dp_out = cmp_model(dp_op, dp_a, dp_b);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Transaction model: one op in flight, timed from its accept cycle
    bit           m_busy;
    int           m_ta;
    logic [N-1:0] m_a, m_b;
    logic [1:0]   m_op;
    bit           m_id;
    bit           m_last;
    int           dut_grants[$];

    task automatic model_reset();
        m_busy = 0;
        m_last = 1;
    endtask

    function automatic int winner(input bit v0, input bit v1);
`ifdef COMPARE_ARB_FIXED_PRIO_EN
        if (v0) return 0;
        if (v1) return 1;
        return -1;
`else
        if (v0 && v1) return m_last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
`endif
    endfunction

    task automatic step(input bit v0, input bit v1, input logic [1:0] op0, input logic [1:0] op1,
                        input logic [N-1:0] a0, input logic [N-1:0] b0,
                        input logic [N-1:0] a1, input logic [N-1:0] b1, input bit rr);
        int w;
        bit exp_dp, exp_rv;
        @(posedge clk);
        #1;
        r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1;
        resp_ready = rr;
        @(negedge clk);
        w      = m_busy ? -1 : winner(v0, v1);
        exp_dp = m_busy && (cyc >= m_ta + 1) && (cyc <= m_ta + LAT);
        exp_rv = m_busy && (cyc > m_ta + LAT);
        check("r0_ready", r0_ready, w == 0);
        check("r1_ready", r1_ready, w == 1);
        check("dp_a", dp_a, exp_dp ? m_a : '0);
        check("dp_b", dp_b, exp_dp ? m_b : '0);
        check("dp_op", dp_op, exp_dp ? m_op : 2'b00);
        check("resp_valid", resp_valid, exp_rv);
        if (exp_rv) begin
            check("resp_data", resp_data, cmp_model(m_op, m_a, m_b));
            check("resp_id", resp_id, m_id);
        end
        if (r0_ready) dut_grants.push_back(0);
        else if (r1_ready) dut_grants.push_back(1);
        if (exp_rv && rr) begin
            m_busy = 0;
        end else if (w >= 0) begin
            m_busy = 1;
            m_ta   = cyc;
            m_id   = (w == 1);
            m_a    = m_id ? a1 : a0;
            m_b    = m_id ? b1 : b0;
            m_op   = m_id ? op1 : op0;
            m_last = m_id;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, 2'b00, '0, '0, '0, '0, 1);
    endtask

    // Async reset pulse starting mid-cycle; outputs must clear at once
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_r0_ready", r0_ready, 0);
        check("rst_r1_ready", r1_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_dp_a", dp_a, 0);
        check("rst_dp_b", dp_b, 0);
        check("rst_dp_op", dp_op, 0);
        r0_valid = 0;
        r1_valid = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One op through the DP_LAT=3 instance with a fresh random dp_out each cycle
    task automatic run_lat3(input bit id, input logic [1:0] op,
                            input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] last_dp;
        last_dp = '0;
        @(posedge clk);
        #1;
        t_r0_valid = !id; t_r1_valid = id;
        t_r0_op = op; t_r1_op = op; t_r0_a = a; t_r0_b = b; t_r1_a = a; t_r1_b = b;
        t_resp_ready = 1'b1;
        t_dp_out = N'($urandom);
        @(negedge clk);
        check("l3_ready0", t_r0_ready, !id);
        check("l3_ready1", t_r1_ready, id);
        check("l3_dp_idle", t_dp_a, 0);
        for (int k = 0; k < LAT3; k++) begin
            @(posedge clk);
            #1;
            t_r0_valid = 0; t_r1_valid = 0;
            t_dp_out = N'($urandom);
            @(negedge clk);
            check("l3_dp_a", t_dp_a, a);
            check("l3_dp_b", t_dp_b, b);
            check("l3_dp_op", t_dp_op, op);
            check("l3_early_resp", t_resp_valid, 0);
            check("l3_busy_ready", t_r1_ready, 0);
            last_dp = t_dp_out;
        end
        @(posedge clk);
        #1;
        t_dp_out = N'($urandom);
        @(negedge clk);
        check("l3_resp_valid", t_resp_valid, 1);
        check("l3_resp_data", t_resp_data, last_dp);
        check("l3_resp_id", t_resp_id, id);
        check("l3_dp_after", t_dp_a, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("l3_resp_done", t_resp_valid, 0);
    endtask

    initial begin
        logic [N-1:0] a0, b0, a1, b1;
        model_reset();
        do_reset();

        // Reset state after release
        #1;
        check("init_resp_valid", resp_valid, 0);
        check("init_dp_op", dp_op, 0);

        // r0 SEQ 5,5
        step(1, 0, OP_SEQ, OP_SEQ, 16'd5, 16'd5, '0, '0, 1);
        idle(4);

        // Both valid continuously from reset
        do_reset();
        dut_grants.delete();
        for (int i = 0; i < 4 * (LAT + 2); i++)
            step(1, 1, OP_SLT, OP_SLE, 16'h0003, 16'h0007, 16'h0009, 16'h0002, 1);
        check("grant_count", dut_grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < dut_grants.size()) begin
`ifdef COMPARE_ARB_FIXED_PRIO_EN
                check("grant_seq", dut_grants[i], 0);
`else
                check("grant_seq", dut_grants[i], i % 2);
`endif
            end
        end
        idle(4);

        // Back-pressure: resp_ready low for 3 RESP cycles, requests pending
        step(1, 0, OP_SLE, OP_SEQ, 16'hFFFF, 16'h0001, '0, '0, 1);
        for (int i = 0; i < LAT + 3; i++)
            step(1, 1, OP_SEQ, OP_SCO, 16'h0011, 16'h0011, 16'h0001, 16'h0002, 0);
        step(0, 0, OP_SEQ, OP_SEQ, '0, '0, '0, '0, 1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            a0 = N'($urandom);
            b0 = ($urandom_range(0, 3) == 0) ? a0 : N'($urandom);
            a1 = N'($urandom);
            b1 = ($urandom_range(0, 3) == 0) ? a1 : N'($urandom);
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 2'($urandom), 2'($urandom), a0, b0, a1, b1, $urandom_range(0, 3) != 0);
        end
        idle(4);

        // Reset in the middle of BUSY drops the op
        step(1, 1, OP_SCO, OP_SEQ, 16'h1234, 16'h4321, 16'h0F0F, 16'h0F0F, 1);
        do_reset();
        idle(3);
        step(0, 1, OP_SEQ, OP_SLT, '0, '0, 16'h8000, 16'h0001, 1);
        idle(4);

        // DP_LAT=3 instance
        run_lat3(1, OP_SLE, 16'hA5A5, 16'h0101);
        run_lat3(0, OP_SCO, 16'h00F1, 16'h7E00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/compare_arb.md
COMPARE_ARB -- requirements
Module: compare_arb

Interface
REQ-001 SHALL have parameter N, default 16, datapath width.
REQ-002 SHALL have parameter DP_LAT, default 1, legal 1..4, cycles the shared compare datapath needs to produce dp_out.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports r0_valid/r1_valid, input, 1 each, requester has an op pending.
REQ-006 SHALL have ports r0_ready/r1_ready, output, 1 each, op accepted this cycle when ANDed with valid.
REQ-007 SHALL have ports r0_a/r0_b/r1_a/r1_b, input, N each, operands.
REQ-008 SHALL have ports r0_op/r1_op, input, 2 each: 00 SEQ, 01 SLT, 10 SLE, 11 SCO.
REQ-009 SHALL have ports dp_a/dp_b, output, N each, and dp_op, output, 2, drive the shared ALU+compare datapath.
REQ-010 SHALL have port dp_out, input, N, datapath result (0 or 1 in LSB).
REQ-011 SHALL have ports resp_valid, output, 1; resp_id, output, 1; resp_data, output, N; resp_ready, input, 1.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-013 In IDLE, SHALL assert rX_ready only for the arbitration winner, only if that rX_valid is high; at most one ready high per cycle.
REQ-014 Valid&ready SHALL latch winner's a, b, op and id into an op register, load latency counter with DP_LAT-1, go to BUSY.
REQ-015 Requests with valid low in IDLE SHALL leave FSM in IDLE; ready SHALL be 0 in BUSY and RESP.
REQ-016 In BUSY, dp_a/dp_b/dp_op SHALL equal the op register; outside BUSY they SHALL be 0.
REQ-017 In BUSY, counter SHALL decrement each cycle; when it is 0, dp_out SHALL be captured into resp_data and FSM goes to RESP.
REQ-018 Accept-to-resp_valid latency SHALL be exactly DP_LAT+1 cycles.
REQ-019 In RESP, resp_valid SHALL be 1 with resp_data/resp_id stable until resp_valid&resp_ready; then FSM goes to IDLE the next cycle.
REQ-020 Throughput SHALL be one op per DP_LAT+2 cycles with resp_ready held high; no new accept in the handshake cycle of RESP.
REQ-021 Arbitration (default): round robin; both valid -> grant requester not granted last; one valid -> grant it; last-grant pointer updates only on accept.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, all ready/resp_valid/resp_id/resp_data/dp_* to 0, counter 0, last-grant pointer 1 (r0 wins first).
REQ-023 Reset in BUSY or RESP SHALL drop the in-flight op with no response; first post-reset accept behaves as from power-up.

Configuration
REQ-024 Macro COMPARE_ARB_FIXED_PRIO_EN defined: r0 SHALL always win when both valid; pointer unused.
REQ-025 Macro undefined: round robin per REQ-021.

Structure
REQ-026 Package cmp_pkg SHALL hold op encodings (SEQ/SLT/SLE/SCO), FSM state encoding, default N.
REQ-027 Two-way arbiter SHALL be sub-module rr_arb2 (inputs valid[1:0], accept; output grant), holding the pointer and the macro-selected policy.

Verification
REQ-028 r0 SEQ a=5 b=5, model dp_out=1, DP_LAT=1: r0_ready cycle 0, dp_op=00 cycle 1, resp_valid cycle 2, resp_data=1, resp_id=0.
REQ-029 Both valid from reset, resp_ready=1, macro undefined: grants r0,r1,r0,r1; with COMPARE_ARB_FIXED_PRIO_EN: r0 every time, r1 never.
REQ-030 resp_ready low 3 cycles in RESP: resp_valid, resp_data, resp_id stable; r0_ready/r1_ready stay 0.
REQ-031 rst_n pulsed low mid-BUSY: all outputs 0 immediately; no resp for dropped op; next r1 SLT a=0x8000 b=1 completes normally.
REQ-032 DP_LAT=3: dp_* held 3 cycles, resp_valid 4 cycles after accept, resp_data = dp_out of last BUSY cycle.
